mem_bank_ctrl: RTL and testbench

- Parametrised, banked single-port synchronous memory with a valid/ready request interface.
- Has a configurable read-latency pipeline and a hardware clear sequencer that sweeps every word to zero.
- Generalises the fixed 4x1024x8 memory model to arbitrary width, depth, bank count and latency.
- Sits between a bus/test master and storage in the memory checker environment.

---
 rtl/mem_bank_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mem_bank_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_ctrl.sv
// Banked single-port memory with a valid/ready request port, a fixed-latency read pipeline and a clear sweep.
// Define MEM_BANK_PARITY_EN to store an even-parity bit per word and flag mismatches on rsp_perr.
module mem_bank_ctrl #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 12,
   parameter int BANK_BITS = 2,
   parameter int RD_LAT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_perr,
   output logic              busy
);

   localparam int DEPTH      = 2 ** ADDR_W;
   localparam int IDX_W      = ADDR_W - BANK_BITS;
   localparam int NUM_BANKS  = 2 ** BANK_BITS;
   localparam int BANK_DEPTH = 2 ** IDX_W;
   localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W:0]   cnt_reg, cnt_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_CLEAR;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_CLEAR: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_WORD) begin
               state_next = ST_RUN;
               cnt_next   = '0;
            end
         end
         ST_RUN: begin
            if (clr) begin
               state_next = ST_CLEAR;
               cnt_next   = '0;
            end
         end
         default: state_next = ST_CLEAR;
      endcase
   end

   assign busy      = (state_reg == ST_CLEAR);
   assign req_ready = (state_reg == ST_RUN) && !cen && !clr;

   logic acc, wr_fire, rd_fire, wr_en;
   logic [ADDR_W-1:0]    wr_addr;
   logic [DATA_W-1:0]    wr_data;
   logic [BANK_BITS-1:0] wr_bank, rd_bank;
   logic [IDX_W-1:0]     wr_idx, rd_idx;

   assign acc     = req_valid && req_ready;
   assign wr_fire = acc && req_wr;
   assign rd_fire = acc && !req_wr;

   // The single write port is shared between the clear sweep and request writes.
   assign wr_en   = busy || wr_fire;
   assign wr_addr = busy ? cnt_reg[ADDR_W-1:0] : req_addr;
   assign wr_data = busy ? '0 : req_wdata;
   assign wr_bank = wr_addr[ADDR_W-1 -: BANK_BITS];
   assign wr_idx  = wr_addr[IDX_W-1:0];
   assign rd_bank = req_addr[ADDR_W-1 -: BANK_BITS];
   assign rd_idx  = req_addr[IDX_W-1:0];

   logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
`ifdef MEM_BANK_PARITY_EN
   logic              bank_rpar  [NUM_BANKS];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         logic [DATA_W-1:0] data_mem [BANK_DEPTH];
         logic [DATA_W-1:0] rdata_reg;

         always_ff @(posedge clk) begin
            if (wr_en && wr_bank == BANK_BITS'(gi))
               data_mem[wr_idx] <= wr_data;
            if (rd_fire && rd_bank == BANK_BITS'(gi))
               rdata_reg <= data_mem[rd_idx];
         end
         assign bank_rdata[gi] = rdata_reg;

`ifdef MEM_BANK_PARITY_EN
         logic par_mem [BANK_DEPTH];
         logic rpar_reg;

         always_ff @(posedge clk) begin
            if (wr_en && wr_bank == BANK_BITS'(gi))
               par_mem[wr_idx] <= ^wr_data;
            if (rd_fire && rd_bank == BANK_BITS'(gi))
               rpar_reg <= par_mem[rd_idx];
         end
         assign bank_rpar[gi] = rpar_reg;
`endif
      end
   endgenerate

   // Stage 0 is the block-RAM output register; the bank tag steers the mux after it.
   logic                 s0_valid_reg;
   logic [BANK_BITS-1:0] s0_bank_reg;
   logic [DATA_W-1:0]    s0_data;
   logic                 s0_perr;

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid_reg <= 1'b0;
      end else begin
         s0_valid_reg <= rd_fire;
         if (rd_fire)
            s0_bank_reg <= rd_bank;
      end
   end

   assign s0_data = bank_rdata[s0_bank_reg];
`ifdef MEM_BANK_PARITY_EN
   assign s0_perr = (^s0_data) ^ bank_rpar[s0_bank_reg];
`else
   assign s0_perr = 1'b0;
`endif

   logic              v_pipe [RD_LAT];
   logic              e_pipe [RD_LAT];
   logic [DATA_W-1:0] d_pipe [RD_LAT];

   generate
      for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
         logic              v_in, e_in;
         logic [DATA_W-1:0] d_in;
         logic              v_reg, e_reg;
         logic [DATA_W-1:0] d_reg;

         if (gi == 0) begin : g_first
            assign v_in = s0_valid_reg;
            assign e_in = s0_perr;
            assign d_in = s0_data;
         end else begin : g_next
            assign v_in = v_pipe[gi-1];
            assign e_in = e_pipe[gi-1];
            assign d_in = d_pipe[gi-1];
         end

         // Payload only moves with a valid beat, so the last stage holds its data between responses.
         always_ff @(posedge clk) begin
            if (rst) begin
               v_reg <= 1'b0;
               e_reg <= 1'b0;
               d_reg <= '0;
            end else begin
               v_reg <= v_in;
               if (v_in) begin
                  e_reg <= e_in;
                  d_reg <= d_in;
               end
            end
         end

         assign v_pipe[gi] = v_reg;
         assign e_pipe[gi] = e_reg;
         assign d_pipe[gi] = d_reg;
      end
   endgenerate

   assign rsp_valid = v_pipe[RD_LAT-1];
   assign rsp_rdata = d_pipe[RD_LAT-1];
   assign rsp_perr  = v_pipe[RD_LAT-1] && e_pipe[RD_LAT-1];

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Scoreboard bench for mem_bank_ctrl: a flat reference array predicts every read, a monitor checks responses.
module tb_mem_bank_ctrl;
   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 12;
   localparam int BANK_BITS = 2;
   localparam int RD_LAT    = 2;
   localparam int DEPTH     = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cen = 1'b0;
   logic              clr = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_wr = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              req_ready, rsp_valid, rsp_perr, busy;
   logic [DATA_W-1:0] rsp_rdata;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int bad_par_addr = -1;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              perr;
      int                due;
   } exp_t;

   exp_t              exp_q [$];
   logic [DATA_W-1:0] ref_mem [DEPTH];

   mem_bank_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_BITS(BANK_BITS), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst), .cen(cen), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference model: sampled on the falling edge, each accept updates the array or queues a prediction.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            automatic exp_t keep [$];
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            foreach (exp_q[i]) if (exp_q[i].due <= cyc) keep.push_back(exp_q[i]);
            exp_q = keep;
         end else begin
            if (clr && !busy)
               for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            if (req_valid && req_ready) begin
               if (req_wr) begin
                  ref_mem[req_addr] = req_wdata;
                  $display("wr  addr=0x%03h data=0x%02h cycle=%0d", req_addr, req_wdata, cyc);
               end else begin
                  automatic exp_t e;
                  e.data = ref_mem[req_addr];
                  e.perr = (int'(req_addr) == bad_par_addr);
                  e.due  = cyc + RD_LAT + 1;
                  exp_q.push_back(e);
               end
            end
         end
      end
   end

   // Monitor: every response must match the oldest prediction and arrive on its scheduled cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rsp_valid) begin
            if (rsp_perr !== 1'b0) fail_now("perr_without_valid");
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
               fail_now("missing_response");
               void'(exp_q.pop_front());
            end
         end else if (exp_q.size() == 0) begin
            fail_now("unexpected_response");
         end else begin
            automatic exp_t e = exp_q.pop_front();
            $display("rd  data=0x%02h perr=%0b cycle=%0d", rsp_rdata, rsp_perr, cyc);
            check("rsp_cycle", 32'(cyc), 32'(e.due));
            check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
            check("rsp_perr", 32'(rsp_perr), 32'(e.perr));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!req_ready) fail_now("issue_timeout");
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_sweep(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < DEPTH + 20) begin
         n++;
         @(negedge clk);
      end
      $display("sweep %s busy_cycles=%0d", name, n);
      check(name, 32'(n), 32'(DEPTH));
      check("ready_after_sweep", 32'(req_ready), 32'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) fail_now("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t0;
      int r;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

      tick(3);
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'(0));
      check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
      check("reset_rsp_rdata", 32'(rsp_rdata), 32'(0));
      check("reset_rsp_perr", 32'(rsp_perr), 32'(0));
      check("reset_busy", 32'(busy), 32'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_sweep("busy_after_reset");

      for (int a = 0; a < DEPTH; a++) issue(1'b0, ADDR_W'(a), '0);
      drain();

      issue(1'b1, 12'h3FF, 8'hA5);
      issue(1'b0, 12'h3FF, '0);
      drain();

      issue(1'b1, 12'h000, 8'h11);
      issue(1'b1, 12'h400, 8'h22);
      issue(1'b1, 12'h800, 8'h33);
      issue(1'b1, 12'hC00, 8'h44);
      t0 = cyc;
      issue(1'b0, 12'h000, '0);
      issue(1'b0, 12'h400, '0);
      issue(1'b0, 12'h800, '0);
      issue(1'b0, 12'hC00, '0);
      check("b2b_read_cycles", 32'(cyc - t0), 32'(4));
      drain();

      // Chip enable blocks new accepts while the earlier read still completes.
      issue(1'b0, 12'h3FF, '0);
      cen = 1'b1;
      req_valid = 1'b1;
      req_wr = 1'b0;
      req_addr = 12'h3FF;
      repeat (4) begin
         @(negedge clk);
         check("ready_with_cen", 32'(req_ready), 32'(0));
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      cen = 1'b0;
      drain();

      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            cen = r[0];
            req_valid = 1'($urandom_range(0, 1));
            req_wr = 1'($urandom_range(0, 1));
            req_addr = ADDR_W'(($urandom_range(0, 3) << 10) | $urandom_range(0, 7));
            req_wdata = DATA_W'($urandom);
            tick(1);
            cen = 1'b0;
            req_valid = 1'b0;
         end else begin
            issue(1'($urandom_range(0, 1)),
                  ADDR_W'(($urandom_range(0, 3) << 10) | $urandom_range(0, 7)),
                  DATA_W'($urandom));
         end
      end
      drain();

      // Clear with a read in flight; a request offered alongside clr must be refused.
      issue(1'b1, 12'h155, 8'h77);
      issue(1'b0, 12'h155, '0);
      clr = 1'b1;
      req_valid = 1'b1;
      req_wr = 1'b0;
      req_addr = 12'h3FF;
      @(negedge clk);
      check("ready_on_clr", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
      clr = 1'b0;
      req_valid = 1'b0;
      wait_sweep("busy_after_clr");
      issue(1'b0, 12'h155, '0);
      issue(1'b0, 12'h3FF, '0);
      issue(1'b0, 12'h800, '0);
      drain();

      // Reset part way through a sweep restarts it from word 0.
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(100);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      wait_sweep("busy_after_midsweep_rst");

      // Reset with a read in flight drops the response and wipes the written word.
      issue(1'b1, 12'h3FF, 8'hA5);
      issue(1'b0, 12'h3FF, '0);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      wait_sweep("busy_after_run_rst");
      issue(1'b0, 12'h3FF, '0);
      drain();

`ifdef MEM_BANK_PARITY_EN
      issue(1'b1, 12'h123, 8'h5A);
      issue(1'b1, 12'h124, 8'h3C);
      tick(1);
      force dut.g_bank[0].par_mem[10'h123] = 1'b1;
      bad_par_addr = 'h123;
      issue(1'b0, 12'h123, '0);
      issue(1'b0, 12'h124, '0);
      drain();
      release dut.g_bank[0].par_mem[10'h123];
      bad_par_addr = -1;
`endif

      tick(5);
      check("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #600000;
      fail_now("watchdog");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
